// File: rtl/timer_bank_if.sv
// Register bus between the processor and timer_bank: address/write-data/strobe
// from the master, combinational read data back from the slave.
interface timer_bank_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
    logic [WIDTH-1:0] rdata;

    modport master (output addr, wdata, we, input rdata);
    modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counting timer bank with per-channel prescaler, reload,
// one-shot/auto-reload mode and sticky expiry flag. Define TIMER_BANK_CAPTURE_EN for input capture.
module timer_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    timer_bank_if.slave         bus,
`ifdef TIMER_BANK_CAPTURE_EN
    input  logic [CHANNELS-1:0] cap_in,
`endif
    output logic                irq,
    output logic [CHANNELS-1:0] irq_vec
);
    localparam logic [3:0] REG_COUNT   = 4'h0;
    localparam logic [3:0] REG_RELOAD  = 4'h1;
    localparam logic [3:0] REG_CTRL    = 4'h2;
    localparam logic [3:0] REG_STATUS  = 4'h3;
    localparam logic [3:0] REG_CAPTURE = 4'h4;

    logic [3:0] ch_sel, reg_sel;
    logic       unused_addr;
    assign ch_sel      = bus.addr[7:4];
    assign reg_sel     = bus.addr[3:0];
    assign unused_addr = &{1'b0, bus.addr[15:8]};

    logic [WIDTH-1:0]    count  [CHANNELS];
    logic [WIDTH-1:0]    reload [CHANNELS];
    logic [PRESC_W-1:0]  presc  [CHANNELS];
    logic [PRESC_W-1:0]  pc     [CHANNELS];
    logic [CHANNELS-1:0] en, auto_rl, irq_en, expired;
    logic [CHANNELS-1:0] wr_count, wr_reload, wr_ctrl, wr_status, tick, expire;
    logic [PRESC_W-1:0]  wr_presc;

    assign wr_presc = bus.wdata[8 +: PRESC_W];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_count  = '0;
        wr_reload = '0;
        wr_ctrl   = '0;
        wr_status = '0;
        tick      = '0;
        expire    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.we && int'(ch_sel) == i) begin
                wr_count[i]  = (reg_sel == REG_COUNT);
                wr_reload[i] = (reg_sel == REG_RELOAD);
                wr_ctrl[i]   = (reg_sel == REG_CTRL);
                wr_status[i] = (reg_sel == REG_STATUS);
            end
            tick[i]   = en[i] && (pc[i] == presc[i]);
            // A COUNT write swallows a coincident tick, including its expiry.
            expire[i] = tick[i] && !wr_count[i] && (count[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-channel arrays are software-visible registers, not RAM, so they are reset.
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
                presc[i]  <= '0;
                pc[i]     <= '0;
            end
            en      <= '0;
            auto_rl <= '0;
            irq_en  <= '0;
            expired <= '0;
            irq_vec <= '0;
            irq     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every channel sees pre-edge state.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!en[i] || tick[i] || (wr_ctrl[i] && wr_presc != presc[i]))
                    pc[i] <= '0;
                else
                    pc[i] <= pc[i] + 1'b1;

                if (wr_count[i])
                    count[i] <= bus.wdata;
                else if (tick[i]) begin
                    if (count[i] != '0)
                        count[i] <= count[i] - 1'b1;
                    else if (auto_rl[i])
                        count[i] <= reload[i];
                end

                if (wr_reload[i])
                    reload[i] <= bus.wdata;

                if (wr_ctrl[i]) begin
                    en[i]      <= bus.wdata[0];
                    auto_rl[i] <= bus.wdata[1];
                    irq_en[i]  <= bus.wdata[2];
                    presc[i]   <= wr_presc;
                end else if (expire[i] && !auto_rl[i]) begin
                    en[i] <= 1'b0;
                end

                if (expire[i])
                    expired[i] <= 1'b1;
                else if (wr_status[i] && bus.wdata[0])
                    expired[i] <= 1'b0;
            end
            irq_vec <= expired & irq_en;
            irq     <= |(expired & irq_en);
        end
    end

`ifdef TIMER_BANK_CAPTURE_EN
    logic [CHANNELS-1:0] cap_s1, cap_s2, cap_s3, captured;
    logic [WIDTH-1:0]    capture [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_s1   <= '0;
            cap_s2   <= '0;
            cap_s3   <= '0;
            captured <= '0;
            for (int i = 0; i < CHANNELS; i++)
                capture[i] <= '0;
        end else begin
            cap_s1 <= cap_in;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            for (int i = 0; i < CHANNELS; i++) begin
                // count[i] here is the pre-edge value, so a coincident COUNT write is not seen.
                if (cap_s2[i] && !cap_s3[i]) begin
                    capture[i]  <= count[i];
                    captured[i] <= 1'b1;
                end else if (wr_status[i] && bus.wdata[1]) begin
                    captured[i] <= 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(ch_sel) == i) begin
                case (reg_sel)
                    REG_COUNT:  bus.rdata = count[i];
                    REG_RELOAD: bus.rdata = reload[i];
                    REG_CTRL: begin
                        bus.rdata[0]             = en[i];
                        bus.rdata[1]             = auto_rl[i];
                        bus.rdata[2]             = irq_en[i];
                        bus.rdata[8 +: PRESC_W]  = presc[i];
                    end
                    REG_STATUS: begin
                        bus.rdata[0] = expired[i];
`ifdef TIMER_BANK_CAPTURE_EN
                        bus.rdata[1] = captured[i];
`endif
                    end
`ifdef TIMER_BANK_CAPTURE_EN
                    REG_CAPTURE: bus.rdata = capture[i];
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
